keypad_emulator: RTL and testbench
==================================

# keypad_emulator

Synthesizable 4x4 matrix-keypad model: the passive responder to the row-scanning keypad reader. It accepts a queue of key codes and "presses" each one for a programmed time. While a key is pressed, it closes the matching row→column contact, so the scanner's one-hot row drive is returned on the column lines. It is used in on-board self-test and in simulation benches, sitting in place of the physical keypad on the row/col nets.

## Interface
Parameters:
- `DEPTH`, 4: key-code FIFO entries (power of two, ≥2).
- `HOLD_CYCLES`, 8: clk cycles per key press (≥ BOUNCE_CYCLES+1).
- `GAP_CYCLES`, 8: clk cycles released between keys (≥ BOUNCE_CYCLES+1).
- `BOUNCE_CYCLES`, 3: contact-bounce window length (used only with bounce compiled in).

Ports:
- `clk` input 1: the single clock, same slow scan clock as the keypad reader.
- `rst` input 1: reset, synchronous, active-high.
- `key_in` input 4: hex key code to enqueue.
- `key_valid` input 1: `key_in` offered.
- `key_ready` output 1: FIFO not full; a push happens on any edge where `key_valid && key_ready`.
- `row` input 4: row drive from the scanner.
- `col` output 4: column return, combinational from `row` and the registered contact state.
- `contact` output 1: the current key is electrically closed.
- `cur_key` output 4: key currently being pressed or released.
- `busy` output 1: FIFO not empty, or FSM not in IDLE.

## Operation
- Key map (row bit r, col bit c):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: E, 0, F, D
- `col[c] = contact && row[kr] && (c == kc)`, where (kr, kc) is the position of `cur_key`.
  - Non-one-hot `row` is legal; only the `row[kr]` bit matters.
  - `row` = 0000 always gives `col` = 0000.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, pop into `cur_key`, clear the counter, go to PRESS.
  - PRESS: count 0..HOLD_CYCLES-1 with `contact` = 1; at the terminal count, clear the counter and go to GAP.
  - GAP: count 0..GAP_CYCLES-1 with `contact` = 0; at the terminal count, go to IDLE.
- FIFO:
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - A push while full is impossible because `key_ready` = 0.
  - A pop while empty never occurs.
- The counter is wide enough for max(HOLD_CYCLES, GAP_CYCLES)-1. No wrap-around in service.
- Reset values: state IDLE, FIFO empty, `contact` 0, `cur_key` 0, counter 0. Consequently `col` 0000, `key_ready` 1, `busy` 0.
- A reset asserted mid-PRESS or mid-GAP aborts the key and flushes the FIFO. `contact` is 0 from the reset edge onward.

## Timing
- Push accepted at edge N → FSM pops at edge N+1 → `contact` = 1 during cycles N+1 .. N+HOLD_CYCLES.
  - Latency from handshake to contact is 1 edge when idle and empty.
- Back-to-back keys: the next PRESS begins one cycle after GAP ends, because IDLE lasts one cycle.
- `key_ready` reflects the registered FIFO count. It rises the cycle after a pop from a full FIFO.
- `col` responds to `row` in the same cycle (no register). This lets the scanner freeze on a non-zero `col`.

## Configuration
- `KEYPAD_EMU_BOUNCE_EN` defined:
  - During the first BOUNCE_CYCLES cycles of PRESS, `contact` = ~counter[0] (1, 0, 1, ...).
  - During the first BOUNCE_CYCLES cycles of GAP, `contact` = counter[0] (0, 1, 0, ...).
  - Outside those windows, `contact` is solid.
- Not defined: `contact` is clean (solid 1 throughout PRESS, solid 0 throughout GAP), and BOUNCE_CYCLES is ignored.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state encoding (IDLE, PRESS, GAP);
  - the key-code constants;
  - the key→(row, col) mapping function, shared with the scanner's decode so both ends use one table.
- Sub-module `keypad_emu_fifo`: synchronous FIFO (DEPTH × 4), with push/pop/full/empty and synchronous reset.
- The FSM, counter, bounce logic and column mux stay in the top module.

## Test plan
- Reset: hold `rst` 2 cycles → `col` = 0000, `key_ready` = 1, `busy` = 0, `contact` = 0.
- Single key: push 0x5 at edge 0, `row` fixed 0010 → `col` = 0010 for cycles 1–8, then 0000 for cycles 9–16, and `busy` = 0 from cycle 18. With `row` = 0001 throughout, `col` stays 0000.
- Queue pressure:
  - Push 1, 2, 3, A, 4, 6 back-to-back with `key_valid` held → `key_ready` drops once 4 entries are held.
  - Pops resume acceptance.
  - Keys are pressed in order 1, 2, 3, A, 4, 6 with 8-cycle holds and gaps.
- Closed loop with the scanner: push 0x0 (r3, c1) → `col` = 0010 only while `row` = 1000. The scanner freezes and its `key_out` becomes 0x0; repeat the same check for 0xD (`col` = 1000).
- Reset mid-PRESS: push 7 then 8, assert `rst` at PRESS cycle 3 → `col` = 0000 from that edge. The FIFO is empty, and key 8 is never pressed.
- With `KEYPAD_EMU_BOUNCE_EN`: push 0x9, `row` = 0100 → `col[2]` pattern is 1, 0, 1, 1, 1, 1, 1, 1 over PRESS, then 0, 1, 0, 0, 0, 0, 0, 0 over GAP.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM encoding, key codes and the key-to-matrix position table
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;
  typedef struct packed {
    logic [1:0] r;
    logic [1:0] c;
  } key_pos_t;
  localparam logic [3:0] KEY_0 = 4'h0, KEY_1 = 4'h1, KEY_2 = 4'h2, KEY_3 = 4'h3;
  localparam logic [3:0] KEY_4 = 4'h4, KEY_5 = 4'h5, KEY_6 = 4'h6, KEY_7 = 4'h7;
  localparam logic [3:0] KEY_8 = 4'h8, KEY_9 = 4'h9, KEY_A = 4'hA, KEY_B = 4'hB;
  localparam logic [3:0] KEY_C = 4'hC, KEY_D = 4'hD, KEY_E = 4'hE, KEY_F = 4'hF;
  function automatic key_pos_t key_pos(input logic [3:0] key);
    case (key)
      KEY_1: key_pos = '{2'd0, 2'd0};
      KEY_2: key_pos = '{2'd0, 2'd1};
      KEY_3: key_pos = '{2'd0, 2'd2};
      KEY_A: key_pos = '{2'd0, 2'd3};
      KEY_4: key_pos = '{2'd1, 2'd0};
      KEY_5: key_pos = '{2'd1, 2'd1};
      KEY_6: key_pos = '{2'd1, 2'd2};
      KEY_B: key_pos = '{2'd1, 2'd3};
      KEY_7: key_pos = '{2'd2, 2'd0};
      KEY_8: key_pos = '{2'd2, 2'd1};
      KEY_9: key_pos = '{2'd2, 2'd2};
      KEY_C: key_pos = '{2'd2, 2'd3};
      KEY_E: key_pos = '{2'd3, 2'd0};
      KEY_0: key_pos = '{2'd3, 2'd1};
      KEY_F: key_pos = '{2'd3, 2'd2};
      default: key_pos = '{2'd3, 2'd3};
    endcase
  endfunction
endpackage

// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: key-code enqueue handshake
interface keypad_emulator_if;
  logic [3:0] key_in;
  logic key_valid;
  logic key_ready;
  modport master(output key_in, key_valid, input key_ready);
  modport slave(input key_in, key_valid, output key_ready);
endinterface

// File: rtl/keypad_emu_fifo.sv
// keypad_emu_fifo: DEPTH x 4 synchronous key-code FIFO
module keypad_emu_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 keypad responder pressing queued keys; define KEYPAD_EMU_BOUNCE_EN for contact bounce
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES = 8,
  parameter int BOUNCE_CYCLES = 3
) (
  input  logic                clk,
  input  logic                rst,
  keypad_emulator_if.slave    kif,
  input  logic [3:0]          row,
  output logic [3:0]          col,
  output logic                contact,
  output logic [3:0]          cur_key,
  output logic                busy
);
  localparam int MAXC = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = MAXC > 2 ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END = CW'(GAP_CYCLES - 1);
  if (HOLD_CYCLES < BOUNCE_CYCLES + 1 || GAP_CYCLES < BOUNCE_CYCLES + 1) begin : g_bad_cfg
    $error("keypad_emulator: HOLD_CYCLES/GAP_CYCLES must exceed BOUNCE_CYCLES");
  end
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] key_n, dout;
  logic push, pop, full, empty;
  key_pos_t pos;
  keypad_emu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop),
    .din(kif.key_in), .dout(dout), .full(full), .empty(empty)
  );
  assign kif.key_ready = !full;
  assign push = kif.key_valid && !full;
  assign busy = !empty || state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      cur_key <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      cur_key <= key_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    key_n = cur_key;
    pop = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        key_n = dout;
        cnt_n = '0;
        state_n = PRESS;
      end
      PRESS: begin
        cnt_n = cnt == HOLD_END ? '0 : cnt + 1'b1;
        state_n = cnt == HOLD_END ? GAP : PRESS;
      end
      GAP: begin
        cnt_n = cnt == GAP_END ? '0 : cnt + 1'b1;
        state_n = cnt == GAP_END ? IDLE : GAP;
      end
      default: state_n = IDLE;
    endcase
  end
`ifdef KEYPAD_EMU_BOUNCE_EN
  logic in_bounce;
  assign in_bounce = cnt < CW'(BOUNCE_CYCLES);
  assign contact = state == PRESS ? (!in_bounce || !cnt[0]) : (state == GAP && in_bounce && cnt[0]);
`else
  assign contact = state == PRESS;
`endif
  // combinational return so the scanner sees its own row drive in the same cycle
  assign pos = key_pos(cur_key);
  assign col = (contact && row[pos.r]) ? 4'b0001 << pos.c : 4'b0000;
endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed checks of press timing, queueing, scanner loop and reset abort
module tb_keypad_emulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] row = 4'b0000;
  logic [3:0] col, cur_key;
  logic contact, busy;
  int n_cmp = 0, n_bad = 0;
  logic [3:0] seq [6] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h6};
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
  keypad_emulator_if kif();
  keypad_emulator #(.DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(8), .BOUNCE_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .kif(kif.slave), .row(row),
    .col(col), .contact(contact), .cur_key(cur_key), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push1(input logic [3:0] k);
    kif.key_in = k;
    kif.key_valid = 1'b1;
    tick();
    kif.key_valid = 1'b0;
  endtask
  task automatic drain(input string tag);
    for (int i = 0; i < 40 && busy; i++) tick();
    check(tag, busy, 0);
  endtask
  function automatic int enc(input logic [3:0] v);
    enc = 0;
    for (int i = 0; i < 4; i++) if (v[i]) enc = i;
  endfunction
  task automatic scan(input logic [3:0] k, input logic [3:0] exp_col);
    logic [3:0] key_out;
    logic frozen;
    int bad;
    key_out = 4'hx;
    frozen = 1'b0;
    bad = 0;
    row = 4'b0001;
    push1(k);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (col != 4'b0000) begin
        if (row != 4'b1000 || col != exp_col) bad++;
        if (!frozen) key_out = kmap[enc(row) * 4 + enc(col)];
        frozen = 1'b1;
      end else if (frozen && i <= 8) bad++;
      else if (!frozen) row = {row[2:0], row[3]};
    end
    check("scan_frozen", frozen, 1);
    check("scan_bad_col", bad, 0);
    check("scan_key_out", key_out, k);
    drain("scan_idle");
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] acc;
    logic seen, rdy, prev;
    logic [15:0] got;
    int e, idx, pressed, high, back;
    kif.key_in = 4'h0;
    kif.key_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_col", col, 0);
    check("rst_ready", kif.key_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_contact", contact, 0);
    row = 4'b0010;
    push1(4'h5);
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i <= 16) check("single_col", col, i <= 8 ? 4'b0010 : 4'b0000);
      if (i == 1) check("single_key", cur_key, 4'h5);
      if (i == 16) check("single_busy_gap", busy, 1);
      if (i == 18) check("single_busy_end", busy, 0);
    end
    row = 4'b0001;
    acc = 4'b0000;
    seen = 1'b0;
    push1(4'h5);
    for (int i = 1; i <= 18; i++) begin
      tick();
      acc |= col;
      seen |= contact;
    end
    check("wrong_row_col", acc, 0);
    check("wrong_row_contact", seen, 1);
    row = 4'b0000;
    idx = 0;
    e = -1;
    pressed = 0;
    high = 0;
    back = -1;
    prev = 1'b0;
    kif.key_in = seq[0];
    kif.key_valid = 1'b1;
    while (e < 200 && (idx < 6 || busy)) begin
      rdy = kif.key_ready;
      tick();
      e++;
      if (rdy && idx < 6) idx++;
      kif.key_valid = idx < 6;
      kif.key_in = seq[idx < 6 ? idx : 5];
      if (e == 4) check("q_full", kif.key_ready, 0);
      if (e > 4 && kif.key_ready && back < 0) back = e;
      if (contact && !prev && pressed < 6) begin
        check("q_order", cur_key, seq[pressed]);
        check("q_start", e, 1 + 17 * pressed);
        pressed++;
      end
      if (contact) high++;
      prev = contact;
    end
    kif.key_valid = 1'b0;
    check("q_timeout", e < 200, 1);
    check("q_ready_back", back, 18);
    check("q_pressed", pressed, 6);
    check("q_hold_total", high, 48);
    scan(4'h0, 4'b0010);
    scan(4'hD, 4'b1000);
    row = 4'b0100;
    push1(4'h7);
    kif.key_in = 4'h8;
    kif.key_valid = 1'b1;
    tick();
    kif.key_valid = 1'b0;
    tick();
    tick();
    check("abort_pre_col", col, 4'b0001);
    rst = 1'b1;
    tick();
    check("abort_col", col, 0);
    check("abort_contact", contact, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", kif.key_ready, 1);
    rst = 1'b0;
    row = 4'b1111;
    acc = 4'b0000;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      acc |= col;
      seen |= busy;
    end
    check("abort_no_key8", acc, 0);
    check("abort_stay_idle", seen, 0);
    row = 4'b0100;
    got = '0;
    push1(4'h9);
    for (int i = 1; i <= 16; i++) begin
      tick();
      got = {got[14:0], col[2]};
    end
`ifdef KEYPAD_EMU_BOUNCE_EN
    check("bounce_pattern", got, 16'b1011_1111_0100_0000);
`else
    check("clean_pattern", got, 16'b1111_1111_0000_0000);
`endif
    drain("final_idle");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
